// File: rtl/micro_fetch_sequencer_pkg.sv
// Shared microword layout, sequencing codes and FSM encoding for the microinstruction stages.
package micro_pkg;

    localparam int SEQ_W  = 2;
    localparam int COND_W = 3;
    localparam int DA_W   = 11;

    localparam logic [SEQ_W-1:0] SEQ_INC  = 2'b00;
    localparam logic [SEQ_W-1:0] SEQ_JMP  = 2'b01;
    localparam logic [SEQ_W-1:0] SEQ_BRC  = 2'b10;
    localparam logic [SEQ_W-1:0] SEQ_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Stage-1 fields, MSB first; da sits directly above the SEQ field in the microword.
    typedef struct packed {
        logic [3:0]      alu;
        logic [1:0]      sh;
        logic            kmx;
        logic [1:0]      m;
        logic [5:0]      b;
        logic [5:0]      c;
        logic [6:0]      t;
        logic [4:0]      a;
        logic [DA_W-1:0] da;
    } uinst_t;

    // Everything above NA in the microword.
    typedef struct packed {
        uinst_t            ui;
        logic [SEQ_W-1:0]  seq;
        logic [COND_W-1:0] cond;
    } mw_ctl_t;

    localparam int     MW_HI_W   = $bits(mw_ctl_t);
    localparam uinst_t NOP_UINST = '0;

endpackage

// File: rtl/micro_fetch_sequencer_if.sv
// Control-store port and stage-1 microinstruction bus of the fetch sequencer.
interface micro_fetch_sequencer_if #(parameter int UPC_W = 8);
    import micro_pkg::*;

    localparam int MW = UPC_W + MW_HI_W;

    logic [UPC_W-1:0] rom_addr;
    logic             rom_en;
    logic [MW-1:0]    rom_data;

    logic [3:0]       ALU_OUT;
    logic [1:0]       SH_OUT;
    logic             KMx_OUT;
    logic [1:0]       M_OUT;
    logic [5:0]       B_OUT;
    logic [5:0]       C_OUT;
    logic [6:0]       T_OUT;
    logic [4:0]       A_OUT;
    logic [DA_W-1:0]  data_address_out;
    logic             uinst_valid;

    modport master (
        output rom_addr, rom_en,
        input  rom_data,
        output ALU_OUT, SH_OUT, KMx_OUT, M_OUT, B_OUT, C_OUT, T_OUT, A_OUT,
        output data_address_out, uinst_valid
    );

    modport slave (
        input  rom_addr, rom_en,
        output rom_data,
        input  ALU_OUT, SH_OUT, KMx_OUT, M_OUT, B_OUT, C_OUT, T_OUT, A_OUT,
        input  data_address_out, uinst_valid
    );

endinterface

// File: rtl/micro_fetch_sequencer_next_addr.sv
// Next-microaddress select: taken JMP/BRC goes to NA, everything else falls through (wrapping).
module micro_next_addr
    import micro_pkg::*;
#(
    parameter int UPC_W = 8
) (
    input  logic [SEQ_W-1:0]  i_seq,
    input  logic [COND_W-1:0] i_cond,
    input  logic [7:0]        i_cond_in,
    input  logic [UPC_W-1:0]  i_upc,
    input  logic [UPC_W-1:0]  i_na,
    output logic [UPC_W-1:0]  o_next_upc,
    output logic              o_take
);

    always_comb begin
        o_take = 1'b0;
        case (i_seq)
            SEQ_JMP: o_take = 1'b1;
            SEQ_BRC: o_take = i_cond_in[i_cond];
            default: o_take = 1'b0;
        endcase
        o_next_upc = o_take ? i_na : i_upc + 1'b1;
    end

endmodule

// File: rtl/micro_fetch_sequencer.sv
// Microprogram fetch/sequence stage: drives the control-store ROM, decodes sequencing,
// and issues one registered microinstruction per cycle to stage 1.
module micro_fetch_sequencer
    import micro_pkg::*;
#(
    parameter int               UPC_W      = 8,
    parameter logic [UPC_W-1:0] START_ADDR = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [UPC_W-1:0]       redirect_addr,
    input  logic [7:0]             cond_in,
    output logic                   halted,
    micro_fetch_sequencer_if.master bus
);

    state_e           r_state, w_state_nxt;
    logic [UPC_W-1:0] r_upc, w_upc_nxt;
    logic             r_pend, w_pend_nxt;
    logic             r_kill, w_kill_nxt;
    uinst_t           r_ui, w_ui_nxt;
    logic             r_vld, w_vld_nxt;

    mw_ctl_t          w_ctl;
    logic [UPC_W-1:0] w_na;
    logic [UPC_W-1:0] w_seq_upc;
    logic             w_take;
    logic             w_word_ok;

    assign w_na      = bus.rom_data[UPC_W-1:0];
    assign w_ctl     = mw_ctl_t'(bus.rom_data[UPC_W +: MW_HI_W]);
    assign w_word_ok = r_pend && !r_kill;

    micro_next_addr #(.UPC_W(UPC_W)) u_next_addr (
        .i_seq      (w_ctl.seq),
        .i_cond     (w_ctl.cond),
        .i_cond_in  (cond_in),
        .i_upc      (r_upc),
        .i_na       (w_na),
        .o_next_upc (w_seq_upc),
        .o_take     (w_take)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_upc   <= '0;
            r_pend  <= 1'b0;
            r_kill  <= 1'b0;
            r_ui    <= NOP_UINST;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            r_pend  <= w_pend_nxt;
            r_kill  <= w_kill_nxt;
            r_ui    <= w_ui_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_pend_nxt  = r_pend;
        w_kill_nxt  = r_kill;
        w_ui_nxt    = r_ui;
        w_vld_nxt   = r_vld;
        if (r_state == ST_RUN && redirect_valid) begin
            // Dropping pend discards both the word now on rom_data and any fetch issued this cycle.
            w_upc_nxt  = redirect_addr;
            w_pend_nxt = 1'b0;
            w_kill_nxt = 1'b0;
            w_ui_nxt   = NOP_UINST;
            w_vld_nxt  = 1'b0;
        end else if (stall) begin
            w_state_nxt = r_state;
        end else if (r_state != ST_RUN) begin
            w_ui_nxt  = NOP_UINST;
            w_vld_nxt = 1'b0;
            if (start) begin
                w_state_nxt = ST_RUN;
                w_upc_nxt   = START_ADDR;
                w_pend_nxt  = 1'b0;
                w_kill_nxt  = 1'b0;
            end
        end else begin
            w_pend_nxt = 1'b1;
            w_kill_nxt = 1'b0;
            w_upc_nxt  = r_upc + 1'b1;
            w_ui_nxt   = NOP_UINST;
            w_vld_nxt  = 1'b0;
            if (w_word_ok) begin
                w_ui_nxt  = w_ctl.ui;
                w_vld_nxt = 1'b1;
                if (w_ctl.seq == SEQ_HALT) begin
                    w_state_nxt = ST_HALTED;
                    w_pend_nxt  = 1'b0;
                    w_upc_nxt   = r_upc;
                end else begin
                    // A taken target replaces the sequential fetch in flight, so that word is killed.
                    w_upc_nxt  = w_seq_upc;
                    w_kill_nxt = w_take;
                end
            end
        end
    end

    assign bus.rom_addr         = r_upc;
    assign bus.rom_en           = (r_state == ST_RUN) && !stall;
    assign bus.ALU_OUT          = r_ui.alu;
    assign bus.SH_OUT           = r_ui.sh;
    assign bus.KMx_OUT          = r_ui.kmx;
    assign bus.M_OUT            = r_ui.m;
    assign bus.B_OUT            = r_ui.b;
    assign bus.C_OUT            = r_ui.c;
    assign bus.T_OUT            = r_ui.t;
    assign bus.A_OUT            = r_ui.a;
    assign bus.data_address_out = r_ui.da;
    assign bus.uinst_valid      = r_vld;
    assign halted               = (r_state == ST_HALTED);

endmodule

// File: tb/tb_micro_fetch_sequencer.sv
// Bench for micro_fetch_sequencer: synchronous ROM model, word-stream reference model, directed scenarios.
module tb_micro_fetch_sequencer;
    import micro_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n, start, stall, redirect_valid;
    logic [7:0] redirect_addr, cond_in;
    logic       halted;

    micro_fetch_sequencer_if #(.UPC_W(8)) bus ();

    micro_fetch_sequencer #(.UPC_W(8), .START_ADDR(8'h00)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .cond_in        (cond_in),
        .halted         (halted),
        .bus            (bus)
    );

    always #5 clock = ~clock;

    logic [56:0] mem [256];

    // Synchronous control store: output updates only on enabled cycles.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)        bus.rom_data <= '0;
        else if (bus.rom_en) bus.rom_data <= mem[bus.rom_addr];
    end

    function automatic logic [56:0] mk(input int a, input logic [1:0] seq,
                                       input logic [2:0] cond, input logic [7:0] na);
        logic [7:0] x;
        uinst_t     u;
        x     = a[7:0];
        u.alu = x[3:0] ^ 4'h5;
        u.sh  = x[1:0];
        u.kmx = x[0];
        u.m   = x[2:1];
        u.b   = x[5:0];
        u.c   = ~x[5:0];
        u.t   = x[6:0];
        u.a   = x[4:0] ^ 5'h1f;
        u.da  = {3'b101, x};
        return {u, seq, cond, na};
    endfunction

    function automatic uinst_t f_ui(input logic [56:0] w);     return w[56:13]; endfunction
    function automatic logic [1:0] f_seq(input logic [56:0] w); return w[12:11]; endfunction
    function automatic logic [2:0] f_cond(input logic [56:0] w); return w[10:8]; endfunction
    function automatic logic [7:0] f_na(input logic [56:0] w);   return w[7:0];  endfunction

    task automatic fill_inc();
        for (int a = 0; a < 256; a++) mem[a] = mk(a, 2'b00, 3'(a), 8'(a * 7 + 3));
    endtask

    // Reference model: which word issues next, and how many bubble cycles precede it.
    int         m_mode;   // 0 idle, 1 run, 2 halted
    logic [7:0] m_next;
    int         m_gap;
    logic       e_vld;
    uinst_t     e_ui;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0; m_next <= 8'h00; m_gap <= 0; e_vld <= 1'b0; e_ui <= '0;
        end else if (m_mode == 1 && redirect_valid) begin
            m_next <= redirect_addr; m_gap <= 1; e_vld <= 1'b0; e_ui <= '0;
        end else if (stall) begin
            m_gap <= m_gap;
        end else if (m_mode != 1) begin
            e_vld <= 1'b0; e_ui <= '0;
            if (start) begin m_mode <= 1; m_next <= 8'h00; m_gap <= 1; end
        end else if (m_gap > 0) begin
            e_vld <= 1'b0; e_ui <= '0; m_gap <= m_gap - 1;
        end else begin
            e_vld <= 1'b1;
            e_ui  <= f_ui(mem[m_next]);
            case (f_seq(mem[m_next]))
                2'b00: m_next <= m_next + 8'd1;
                2'b01: begin m_next <= f_na(mem[m_next]); m_gap <= 1; end
                2'b10: if (cond_in[f_cond(mem[m_next])]) begin
                           m_next <= f_na(mem[m_next]); m_gap <= 1;
                       end else m_next <= m_next + 8'd1;
                default: m_mode <= 2;
            endcase
        end
    end

    int   n_cmp = 0;
    int   n_err = 0;
    logic chk_on = 1'b0;
    int   trace[$];
    int   exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, req);
        end
    endtask

    task automatic check_trace(input string nm);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= trace.size() || trace[i] != exp_q[i]) begin
                n_err++;
                $display("FAIL %s[%0d] got=%0d expected=%0d", nm, i,
                         (i < trace.size()) ? trace[i] : -999, exp_q[i]);
            end
        end
    endtask

    task automatic compare_loop();
        uinst_t act;
        forever begin
            @(negedge clock);
            if (chk_on) begin
                act = {bus.ALU_OUT, bus.SH_OUT, bus.KMx_OUT, bus.M_OUT, bus.B_OUT,
                       bus.C_OUT, bus.T_OUT, bus.A_OUT, bus.data_address_out};
                check("valid", 64'(bus.uinst_valid), 64'(e_vld));
                check("word", 64'(act), 64'(e_ui));
                check("halted", 64'(halted), 64'(m_mode == 2));
                trace.push_back(bus.uinst_valid ? int'(bus.data_address_out[7:0]) : -1);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_start();
        start = 1'b1;
        step();
        start = 1'b0;
        trace.delete();
    endtask

    task automatic stimulus();
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_addr = 8'h00; cond_in = 8'h00;
        fill_inc();
        repeat (2) step();
        check("rst_valid", 64'(bus.uinst_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_rom_en", 64'(bus.rom_en), 64'd0);
        check("rst_da", 64'(bus.data_address_out), 64'd0);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        step();

        // Straight line with a 3-cycle stall after word 1; HALT at 6.
        fill_inc();
        mem[6] = mk(6, SEQ_HALT, 3'd0, 8'h00);
        run_start();
        repeat (3) step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        repeat (10) step();
        exp_q = '{-1, -1, 0, 1, 1, 1, 1, 2, 3, 4, 5, 6, -1, -1, -1, -1};
        check_trace("line_stall");
        check("line_halted", 64'(halted), 64'd1);

        // JMP at 2 to 0x40, restarted from HALTED.
        fill_inc();
        mem[2]    = mk(2, SEQ_JMP, 3'd0, 8'h40);
        mem[8'h42] = mk(8'h42, SEQ_HALT, 3'd0, 8'h00);
        run_start();
        repeat (10) step();
        exp_q = '{-1, -1, 0, 1, 2, -1, 'h40, 'h41, 'h42, -1};
        check_trace("jmp");

        // BRC COND=5 taken.
        fill_inc();
        mem[1]     = mk(1, SEQ_BRC, 3'd5, 8'h20);
        mem[3]     = mk(3, SEQ_HALT, 3'd0, 8'h00);
        mem[8'h21] = mk(8'h21, SEQ_HALT, 3'd0, 8'h00);
        cond_in = 8'h20;
        run_start();
        repeat (8) step();
        exp_q = '{-1, -1, 0, 1, -1, 'h20, 'h21, -1};
        check_trace("brc_taken");

        // BRC not taken (all other flags set), plus a start pulse while running.
        cond_in = 8'hDF;
        run_start();
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        exp_q = '{-1, -1, 0, 1, 2, 3, -1};
        check_trace("brc_fall");

        // Redirect to 0x10 while stalled; HALT at 0x11.
        fill_inc();
        mem[8'h11] = mk(8'h11, SEQ_HALT, 3'd0, 8'h00);
        run_start();
        repeat (4) step();
        redirect_valid = 1'b1; redirect_addr = 8'h10; stall = 1'b1;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        repeat (5) step();
        exp_q = '{-1, -1, 0, 1, 2, -1, -1, 'h10, 'h11, -1};
        check_trace("redirect_stall");
        check("redirect_halted", 64'(halted), 64'd1);

        // Redirect to 0xFE overrides the HALT at 1; address wraps 0xFF -> 0.
        fill_inc();
        mem[1] = mk(1, SEQ_HALT, 3'd0, 8'h00);
        run_start();
        repeat (2) step();
        redirect_valid = 1'b1; redirect_addr = 8'hFE;
        step();
        redirect_valid = 1'b0;
        repeat (7) step();
        exp_q = '{-1, -1, 0, -1, -1, 'hFE, 'hFF, 0, 1, -1};
        check_trace("wrap");

        // Asynchronous reset mid-run.
        fill_inc();
        run_start();
        repeat (4) step();
        check("pre_rst_valid", 64'(bus.uinst_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.uinst_valid), 64'd0);
        check("mid_rst_da", 64'(bus.data_address_out), 64'd0);
        check("mid_rst_alu", 64'(bus.ALU_OUT), 64'd0);
        check("mid_rst_halted", 64'(halted), 64'd0);
        check("mid_rst_rom_en", 64'(bus.rom_en), 64'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // In IDLE: redirect ignored, start ignored under stall.
        redirect_valid = 1'b1; redirect_addr = 8'h33; stall = 1'b1; start = 1'b1;
        step();
        redirect_valid = 1'b0; stall = 1'b0; start = 1'b0;
        repeat (3) step();
        check("idle_rom_en", 64'(bus.rom_en), 64'd0);
        check("idle_valid", 64'(bus.uinst_valid), 64'd0);
        step();
    endtask

    initial begin
        fork
            compare_loop();
            stimulus();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
